// File: rtl/sub32_pipe.sv
// sub32_pipe: four-lane saturating SIMD subtractor, two-stage valid/ready pipe.
// Per-operand signedness travels with each op; sticky saturation counter.
module sub32_pipe #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   src0,
  input  logic [LANES*32-1:0]   src1,
  input  logic                  sign_s0,
  input  logic                  sign_s1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*32-1:0]   dst,
  output logic [LANES-1:0]      sat,
  output logic [CNT_W-1:0]      sat_cnt,
  input  logic                  sat_cnt_clr
);

  localparam int W = LANES * 32;

  logic             s1_valid_q;
  logic [W-1:0]     s1_a_q;
  logic [W-1:0]     s1_b_q;
  logic             s1_sa_q;
  logic             s1_sb_q;
  logic             s2_valid_q;
  logic [W-1:0]     dst_q;
  logic [LANES-1:0] sat_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s1_adv;
  logic             s2_adv;
  logic             acc;
  logic             hs;
  logic [W-1:0]     dst_d;
  logic [LANES-1:0] sat_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   sum;
  logic [33:0]      a;
  logic [33:0]      b;
  logic [33:0]      d;

  assign s2_adv    = !s2_valid_q | out_ready;
  assign s1_adv    = !s1_valid_q | s2_adv;
  assign in_ready  = s1_adv;
  assign acc       = in_valid & s1_adv;
  assign hs        = s2_valid_q & out_ready;
  assign out_valid = s2_valid_q;
  assign dst       = dst_q;
  assign sat       = sat_q;
  assign sat_cnt   = cnt_q;

  // 34-bit difference is exact for any mix of signed/unsigned 32-bit operands
  always_comb begin
    dst_d = '0;
    sat_d = '0;
    a     = '0;
    b     = '0;
    d     = '0;
    for (int i = 0; i < LANES; i++) begin
      a = {{2{s1_sa_q & s1_a_q[i*32+31]}}, s1_a_q[i*32 +: 32]};
      b = {{2{s1_sb_q & s1_b_q[i*32+31]}}, s1_b_q[i*32 +: 32]};
      d = a - b;
      dst_d[i*32 +: 32] = d[31:0];
      if (s1_sa_q | s1_sb_q) begin
        if (!d[33] && (d[32] || d[31])) begin
          dst_d[i*32 +: 32] = 32'h7FFF_FFFF;
          sat_d[i] = 1'b1;
        end else if (d[33] && !(d[32] && d[31])) begin
          dst_d[i*32 +: 32] = 32'h8000_0000;
          sat_d[i] = 1'b1;
        end
      end else if (d[33]) begin
        dst_d[i*32 +: 32] = 32'h0000_0000;
        sat_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + (CNT_W+1)'(sat_q[i]);
    end
    sum = {1'b0, cnt_q} + pop;
    cnt_d = cnt_q;
    if (sat_cnt_clr) begin
      cnt_d = hs ? pop[CNT_W-1:0] : '0;
    end else if (hs) begin
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      dst_q      <= '0;
      sat_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
      end
      if (acc) begin
        s1_a_q  <= src0;
        s1_b_q  <= src1;
        s1_sa_q <= sign_s0;
        s1_sb_q <= sign_s1;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          dst_q <= dst_d;
          sat_q <= sat_d;
        end
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sub32_pipe.sv
// tb_sub32_pipe: table vectors, directed pipeline sequences and random
// traffic scored against an arithmetic reference model.
module tb_sub32_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] src0;
  logic [127:0] src1;
  logic         sign_s0;
  logic         sign_s1;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dst;
  logic [3:0]   sat;
  logic [15:0]  sat_cnt;
  logic         sat_cnt_clr;

  int checks = 0;
  int errors = 0;

  sub32_pipe #(.LANES(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src0       (src0),
    .src1       (src1),
    .sign_s0    (sign_s0),
    .sign_s1    (sign_s1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dst        (dst),
    .sat        (sat),
    .sat_cnt    (sat_cnt),
    .sat_cnt_clr(sat_cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] dst;
    logic [3:0]   sat;
  } res_t;

  typedef struct {
    logic [127:0] s0;
    logic [127:0] s1;
    logic         sa;
    logic         sb;
    logic [127:0] edst;
    logic [3:0]   esat;
  } vec_t;

  res_t sb[$];
  int   cnt_m = 0;
  logic stall_q = 1'b0;
  logic [127:0] hold_dst;
  logic [3:0]   hold_sat;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic res_t model(logic [127:0] s0, logic [127:0] s1,
                                 logic sa, logic sb_f);
    res_t r;
    longint x, y, df;
    logic [31:0] u, v;
    r.dst = '0;
    r.sat = '0;
    for (int i = 0; i < 4; i++) begin
      u = s0[i*32 +: 32];
      v = s1[i*32 +: 32];
      x = sa   ? longint'($signed(u)) : longint'(u);
      y = sb_f ? longint'($signed(v)) : longint'(v);
      df = x - y;
      if (sa || sb_f) begin
        if (df > 64'sd2147483647) begin
          r.dst[i*32 +: 32] = 32'h7FFF_FFFF;
          r.sat[i] = 1'b1;
        end else if (df < -64'sd2147483648) begin
          r.dst[i*32 +: 32] = 32'h8000_0000;
          r.sat[i] = 1'b1;
        end else begin
          r.dst[i*32 +: 32] = df[31:0];
        end
      end else if (df < 0) begin
        r.dst[i*32 +: 32] = 32'h0;
        r.sat[i] = 1'b1;
      end else begin
        r.dst[i*32 +: 32] = df[31:0];
      end
    end
    return r;
  endfunction

  // Scoreboard/monitor: inputs change just after posedge, so the negedge
  // view shows exactly what the next rising edge will act on.
  always @(negedge clk) begin
    res_t e;
    int   pop;
    logic hs;
    if (rst) begin
      sb.delete();
      cnt_m   = 0;
      stall_q = 1'b0;
    end else begin
      chk("sat_cnt_track", 128'(sat_cnt), 128'(cnt_m));
      if (stall_q && out_valid) begin
        chk("stall_dst_hold", dst, hold_dst);
        chk("stall_sat_hold", 128'(sat), 128'(hold_sat));
      end
      hs  = out_valid && out_ready;
      pop = 0;
      if (hs) begin
        if (sb.size() == 0) begin
          chk("spurious_output", 128'(1), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("sb_dst", dst, e.dst);
          chk("sb_sat", 128'(sat), 128'(e.sat));
          pop = $countones(e.sat);
        end
      end
      if (sat_cnt_clr) cnt_m = hs ? pop : 0;
      else if (hs) cnt_m = (cnt_m + pop > 65535) ? 65535 : cnt_m + pop;
      if (in_valid && in_ready)
        sb.push_back(model(src0, src1, sign_s0, sign_s1));
      stall_q  = out_valid && !out_ready;
      hold_dst = dst;
      hold_sat = sat;
    end
  end

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  vec_t tbl[4];
  int   lat, fo, nres, nacc, seen;

  initial begin
    tbl[0] = '{{32'h0, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF},
               {32'h0, 32'd7, 32'h0000_0001, 32'hFFFF_FFFF}, 1'b1, 1'b1,
               {32'h0, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF}, 4'b0011};
    tbl[1] = '{{32'd10, 32'd0, 32'hFFFF_FFFF, 32'd3},
               {32'd4, 32'd0, 32'd1, 32'd5}, 1'b0, 1'b0,
               {32'd6, 32'd0, 32'hFFFF_FFFE, 32'd0}, 4'b0001};
    tbl[2] = '{{32'h8000_0000, 32'h10, 32'h0, 32'hFFFF_FFFF},
               {32'h0, 32'hFFFF_FFF0, 32'h1, 32'hFFFF_FFFF}, 1'b0, 1'b1,
               {32'h7FFF_FFFF, 32'h20, 32'hFFFF_FFFF, 32'h7FFF_FFFF}, 4'b1001};
    tbl[3] = '{{32'd7, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF},
               {32'd2, 32'hFFFF_FFFF, 32'h1, 32'h1}, 1'b1, 1'b0,
               {32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFE}, 4'b0110};

    rst = 1'b1;
    in_valid = 1'b0;
    src0 = '0;
    src1 = '0;
    sign_s0 = 1'b0;
    sign_s1 = 1'b0;
    out_ready = 1'b1;
    sat_cnt_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_dst", dst, 128'(0));
    chk("reset_sat", 128'(sat), 128'(0));
    chk("reset_sat_cnt", 128'(sat_cnt), 128'(0));

    // Table vectors, one at a time
    for (int k = 0; k < 4; k++) begin
      src0 = tbl[k].s0;
      src1 = tbl[k].s1;
      sign_s0 = tbl[k].sa;
      sign_s1 = tbl[k].sb;
      in_valid = 1'b1;
      chk("tbl_in_ready", 128'(in_ready), 128'(1));
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        tick();
        lat++;
      end
      chk("tbl_latency", 128'(lat), 128'(2));
      chk("tbl_dst", dst, tbl[k].edst);
      chk("tbl_sat", 128'(sat), 128'(tbl[k].esat));
      tick();
      if (k == 0) chk("tbl_sat_cnt_first", 128'(sat_cnt), 128'(2));
    end
    chk("tbl_sat_cnt_total", 128'(sat_cnt), 128'(7));

    // Back-to-back throughput
    fo = -1;
    nres = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      src0 = {rnd32(), rnd32(), rnd32(), rnd32()};
      src1 = {rnd32(), rnd32(), rnd32(), rnd32()};
      sign_s0 = 1'($urandom);
      sign_s1 = 1'($urandom);
      if (i < 8) chk("thru_in_ready", 128'(in_ready), 128'(1));
      tick();
      if (out_valid && fo < 0) fo = i;
      if (out_valid && i >= 1 && i <= 8) nres++;
    end
    chk("thru_first_out", 128'(fo), 128'(1));
    chk("thru_consecutive", 128'(nres), 128'(8));
    chk("thru_drained", 128'(sb.size()), 128'(0));

    // Backpressure: only two ops fit
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      src0 = {rnd32(), rnd32(), rnd32(), rnd32()};
      src1 = {rnd32(), rnd32(), rnd32(), rnd32()};
      sign_s0 = 1'($urandom);
      sign_s1 = 1'($urandom);
      #1;
      if (in_ready) nacc++;
      tick();
    end
    chk("bp_accepted", 128'(nacc), 128'(2));
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_drained", 128'(sb.size()), 128'(0));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      sat_cnt_clr = ($urandom_range(0, 49) == 0);
      src0 = {rnd32(), rnd32(), rnd32(), rnd32()};
      src1 = {rnd32(), rnd32(), rnd32(), rnd32()};
      sign_s0 = 1'($urandom);
      sign_s1 = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    sat_cnt_clr = 1'b0;
    repeat (4) tick();
    chk("rand_drained", 128'(sb.size()), 128'(0));

    // Reset with two ops in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    sign_s0 = 1'b0;
    sign_s1 = 1'b0;
    src0 = '0;
    src1 = {4{32'h1}};
    repeat (2) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_sat_cnt", 128'(sat_cnt), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_no_stale", 128'(seen), 128'(0));

    // Counter saturation: 16383 four-sat ops plus one two-sat op = 0xFFFE
    in_valid = 1'b1;
    src0 = '0;
    src1 = {4{32'h1}};
    repeat (16383) tick();
    src1 = {32'h0, 32'h0, 32'h1, 32'h1};
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("cnt_fffe", 128'(sat_cnt), 128'(16'hFFFE));
    src1 = {4{32'h1}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("cnt_clamp_ffff", 128'(sat_cnt), 128'(16'hFFFF));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("cnt_stick_ffff", 128'(sat_cnt), 128'(16'hFFFF));

    // Clear concurrent with a three-sat handshake
    out_ready = 1'b0;
    src1 = {32'h0, 32'h1, 32'h1, 32'h1};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk("clr_out_valid", 128'(out_valid), 128'(1));
    sat_cnt_clr = 1'b1;
    out_ready = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    chk("clr_with_hs", 128'(sat_cnt), 128'(3));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub32_pipe.md
Name: sub32_pipe

Overview:
- Four-lane SIMD 32-bit integer subtractor with per-operand signedness and saturating results.
- The subtract-direction counterpart of the SMC lane adder: computes dst = src0 − src1 per 32-bit lane.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Keeps a sticky count of saturation events for the SMC status path.

Parameters:
- LANES, 4, number of 32-bit lanes (bus width = LANES*32).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  src0/src1/sign_s0/sign_s1 carry a valid operation.
- in_ready  output  1  block accepts the operation this cycle.
- src0  input  LANES*32  minuend; lane i = bits [i*32+31 : i*32].
- src1  input  LANES*32  subtrahend, same lane packing.
- sign_s0  input  1  1 = src0 lanes are two's-complement signed; 0 = unsigned.
- sign_s1  input  1  1 = src1 lanes are signed; 0 = unsigned.
- out_valid  output  1  dst/sat are valid.
- out_ready  input  1  downstream consumes the result this cycle.
- dst  output  LANES*32  saturated differences.
- sat  output  LANES  per-lane flag: lane result was clamped.
- sat_cnt  output  CNT_W  number of lanes saturated since reset/clear; sticks at all-ones.
- sat_cnt_clr  input  1  synchronous clear of sat_cnt.

Behaviour:
- Reset values: in_ready=1 (combinational, follows the empty pipe), out_valid=0, dst=0, sat=0, sat_cnt=0. Both stage valid bits are cleared; in-flight operations are discarded. Reset has priority over every other input.
- Arithmetic, per lane:
  - Extend a and b to 34 bits: sign-extend if the operand's sign flag = 1, else zero-extend.
  - d = a − b, exact in 34 bits.
  - Signed mode (sign_s0 | sign_s1): clamp d to [−2^31, 2^31−1]. d > 0x7FFFFFFF → 0x7FFFFFFF, sat=1. d < −2^31 → 0x80000000, sat=1.
  - Unsigned mode (both flags 0): clamp to [0, 2^32−1]. d < 0 → 0x00000000, sat=1.
  - Otherwise dst = d[31:0], sat=0.
- Pipeline:
  - S1 registers the operands and flags on acceptance. S2 registers dst and sat.
  - Accept occurs when in_valid & in_ready.
  - Latency is 2 cycles: an op accepted at edge N presents out_valid at edge N+2 if not stalled.
- Flow control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. A combinational out_ready→in_ready path is permitted.
  - Full throughput: 1 op/cycle while out_ready=1.
- Stall: while out_valid=1 & out_ready=0, dst/sat are held stable. S1 may still fill, so at most 2 ops are in flight. When both stages are full, in_ready=0.
- No bubbles on release: when out_ready rises with both stages full, S1 moves to S2 on the same edge, and a new input is accepted if in_valid.
- Inputs are ignored when in_valid=0. Data is don't-care when the corresponding valid is 0; only valid bits gate the state machine.
- sat_cnt:
  - Increments by popcount(sat) on each output handshake (out_valid & out_ready).
  - Saturates at 2^CNT_W−1; it never wraps. An increment that would overshoot is clamped to all-ones.
  - sat_cnt_clr with a simultaneous handshake: the counter loads popcount of the current handshake's sat (clear-then-count).
- Signedness flags travel with their operation through the pipe. A flag change between ops never affects an in-flight op.

Test Plan:
- Signed overflow: sign_s0=sign_s1=1, lane0 0x7FFFFFFF − 0xFFFFFFFF(−1) -> dst lane0 0x7FFFFFFF, sat[0]=1. Lane1 0x80000000 − 0x00000001 -> 0x80000000, sat[1]=1. Lane2 5−7 -> 0xFFFFFFFE, sat[2]=0. Lane3 0−0 -> 0, sat[3]=0. sat_cnt=2 after handshake.
- Unsigned underflow: both flags 0, lane0 3−5 -> 0x00000000, sat[0]=1. Lane1 0xFFFFFFFF−1 -> 0xFFFFFFFE, sat[1]=0.
- Mixed signedness: sign_s0=0, sign_s1=1, lane0 0xFFFFFFFF − 0xFFFFFFFF(−1) -> 2^32 exact -> 0x7FFFFFFF, sat[0]=1. sign_s0=1, sign_s1=0, lane0 0xFFFFFFFF(−1) − 0x00000001 -> 0xFFFFFFFE, sat=0.
- Latency and throughput: 8 back-to-back ops, out_ready=1 -> first out_valid 2 cycles after first accept, 8 consecutive results in order, in_ready never drops.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 ops accepted, in_ready=0 thereafter, dst stable. Release -> results in order, no loss or duplication.
- Reset and counter: assert rst with 2 ops in flight -> out_valid=0 next cycle, sat_cnt=0, no stale output after deassert. Force sat_cnt to 0xFFFE via 0xFFFE saturating lanes, then a 4-sat handshake -> 0xFFFF. sat_cnt_clr concurrent with a 3-sat handshake -> 3.
